// File: rtl/sar_seq_pkg.sv
// Shared types for the SAR conversion sequencer: one-hot state, strobe map, parameter checks.
// Pure declarations; no clocked logic lives here.
package sar_seq_pkg;

    localparam int SAMP_W = 8;

    typedef enum logic [5:0] {
        ST_IDLE = 6'b000001,
        ST_INIT = 6'b000010,
        ST_SAMP = 6'b000100,
        ST_COMP = 6'b001000,
        ST_UPD  = 6'b010000,
        ST_DONE = 6'b100000
    } state_t;

    typedef struct packed {
        logic init;
        logic samp;
        logic comp;
        logic update;
    } seq_t;

    function automatic seq_t seq_map(state_t s);
        seq_t m;
        m = '0;
        case (s)
            ST_INIT: m.init   = 1'b1;
            ST_SAMP: m.samp   = 1'b1;
            ST_COMP: m.comp   = 1'b1;
            ST_UPD:  m.update = 1'b1;
            default: m        = '0;
        endcase
        return m;
    endfunction

    function automatic bit nbits_ok(int n);
        return (n >= 1) && (n <= 16);
    endfunction

    function automatic bit samp_cyc_ok(int n);
        return (n >= 1) && (n <= 255);
    endfunction

endpackage

// File: rtl/sar_seq_if.sv
// Request/strobe bundle between the conversion sequencer and its user (master drives start/abort).
interface sar_seq_if #(parameter int NBITS = 8);

    localparam int IW = $clog2(NBITS) + 1;

    logic          start;
    logic          abort;
    logic          seq_init;
    logic          seq_samp;
    logic          seq_comp;
    logic          seq_update;
    logic [IW-1:0] bit_idx;
    logic          busy;
    logic          done;

    modport master (
        output start, abort,
        input  seq_init, seq_samp, seq_comp, seq_update, bit_idx, busy, done
    );

    modport slave (
        input  start, abort,
        output seq_init, seq_samp, seq_comp, seq_update, bit_idx, busy, done
    );

endinterface

// File: rtl/sar_seq_cnt.sv
// Loadable down-counter with zero flag; load wins over dec, and dec stops at zero.
// Count updates one edge after load/dec; zero is combinational from the count.
module sar_seq_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    assign zero = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !zero) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/sar_seq.sv
// SAR conversion sequencer: registered init/sample/compare/update strobes, bit index and done pulse.
// start in IDLE -> seq_init next cycle; abort cancels at next edge; SAR_SEQ_CONTINUOUS_EN makes DONE loop to INIT.
module sar_seq
    import sar_seq_pkg::*;
#(
    parameter int NBITS    = 8,
    parameter int SAMP_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    sar_seq_if.slave   bus
);

    localparam int IW = $clog2(NBITS) + 1;

    if (!nbits_ok(NBITS)) begin : g_bad_nbits
        $error("sar_seq: NBITS must be in 1..16");
    end
    if (!samp_cyc_ok(SAMP_CYC)) begin : g_bad_samp
        $error("sar_seq: SAMP_CYC must be in 1..255");
    end

    state_t              state;
    state_t              state_nxt;
    logic                samp_zero;
    logic                bit_zero;
    logic [SAMP_W-1:0]   samp_cnt;
    logic [IW-1:0]       bit_cnt;
    logic                samp_load;
    logic                samp_dec;
    logic                bit_load;
    logic                bit_dec;
    seq_t                seq_q;
    logic                busy_q;
    logic                done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.start) state_nxt = ST_INIT;
            ST_INIT: state_nxt = ST_SAMP;
            ST_SAMP: if (samp_zero) state_nxt = ST_COMP;
            ST_COMP: state_nxt = ST_UPD;
            ST_UPD:  state_nxt = bit_zero ? ST_DONE : ST_COMP;
`ifdef SAR_SEQ_CONTINUOUS_EN
            ST_DONE: state_nxt = ST_INIT;
`else
            ST_DONE: state_nxt = ST_IDLE;
`endif
            default: state_nxt = ST_IDLE;
        endcase
        if (bus.abort && (state != ST_IDLE)) begin
            state_nxt = ST_IDLE;
        end
    end

    // Counter controls key off the actual transition so an abort never disturbs them.
    assign samp_load = (state == ST_INIT) && (state_nxt == ST_SAMP);
    assign samp_dec  = (state == ST_SAMP) && (state_nxt == ST_SAMP);
    assign bit_load  = (state == ST_SAMP) && (state_nxt == ST_COMP);
    assign bit_dec   = (state == ST_UPD)  && (state_nxt == ST_COMP);

    sar_seq_cnt #(.W(SAMP_W)) u_samp_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (samp_load),
        .load_val (SAMP_W'(SAMP_CYC - 1)),
        .dec      (samp_dec),
        .cnt      (samp_cnt),
        .zero     (samp_zero)
    );

    sar_seq_cnt #(.W(IW)) u_bit_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (bit_load),
        .load_val (IW'(NBITS - 1)),
        .dec      (bit_dec),
        .cnt      (bit_cnt),
        .zero     (bit_zero)
    );

    // Only the zero flag steers SAMP; the raw sample count has no consumer.
    logic unused_samp;
    assign unused_samp = ^samp_cnt;

    // Strobes are registered copies of the next-state decode, so they track state with no glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            seq_q  <= seq_map(state_nxt);
            busy_q <= (state_nxt != ST_IDLE);
            done_q <= (state_nxt == ST_DONE);
        end
    end

    assign bus.seq_init   = seq_q.init;
    assign bus.seq_samp   = seq_q.samp;
    assign bus.seq_comp   = seq_q.comp;
    assign bus.seq_update = seq_q.update;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.bit_idx    = bit_cnt;

endmodule

// File: tb/tb_sar_seq.sv
// Scoreboard bench for sar_seq: expected per-cycle output vectors are queued at start and checked each cycle.
module tb_sar_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sar_seq_if #(.NBITS(8)) bus1 ();
    sar_seq_if #(.NBITS(1)) bus2 ();

    sar_seq #(.NBITS(8), .SAMP_CYC(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    sar_seq #(.NBITS(1), .SAMP_CYC(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    int          n_chk = 0;
    int          n_bad = 0;
    logic [31:0] sb[$];

    task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Vector layout: {init, samp, comp, update, busy, done, bit_idx[3:0]}
    function automatic logic [31:0] ev(bit i, bit s, bit c, bit u, bit b, bit d, int bi);
        return {22'b0, i, s, c, u, b, d, 4'(bi)};
    endfunction

    function automatic logic [31:0] obs1();
        return {22'b0, bus1.seq_init, bus1.seq_samp, bus1.seq_comp, bus1.seq_update,
                bus1.busy, bus1.done, bus1.bit_idx};
    endfunction

    function automatic logic [31:0] obs2();
        return {22'b0, bus2.seq_init, bus2.seq_samp, bus2.seq_comp, bus2.seq_update,
                bus2.busy, bus2.done, 3'b0, bus2.bit_idx};
    endfunction

    function automatic logic [31:0] idle_v(int bi);
        return ev(0, 0, 0, 0, 0, 0, bi);
    endfunction

    // Queue one conversion's expected trace; limit < 0 means the whole conversion.
    task automatic push_conv(int nb, int sc, int prev, int limit);
        logic [31:0] tr[$];
        tr.push_back(ev(1, 0, 0, 0, 1, 0, prev));
        for (int k = 0; k < sc; k++) tr.push_back(ev(0, 1, 0, 0, 1, 0, prev));
        for (int b = nb - 1; b >= 0; b--) begin
            tr.push_back(ev(0, 0, 1, 0, 1, 0, b));
            tr.push_back(ev(0, 0, 0, 1, 1, 0, b));
        end
        tr.push_back(ev(0, 0, 0, 0, 1, 1, 0));
        for (int k = 0; k < tr.size(); k++) begin
            if (limit < 0 || k < limit) sb.push_back(tr[k]);
        end
    endtask

    // Pop one expected vector per cycle; drop start/abort at drop_at, raise abort at abort_at.
    task automatic run_sb(int which, string tag, int drop_at, int abort_at);
        int i;
        logic [31:0] exp;
        i = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            if (i == drop_at) begin
                if (which == 1) begin bus1.start = 1'b0; bus1.abort = 1'b0; end
                else            begin bus2.start = 1'b0; bus2.abort = 1'b0; end
            end
            if (i == abort_at) begin
                if (which == 1) bus1.abort = 1'b1;
                else            bus2.abort = 1'b1;
            end
            exp = sb.pop_front();
            check_val($sformatf("%s[%0d]", tag, i), (which == 1) ? obs1() : obs2(), exp);
            i++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        bus1.start = 1'b0;
        bus1.abort = 1'b0;
        bus2.start = 1'b0;
        bus2.abort = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_dut1", obs1(), idle_v(0));
        check_val("reset_dut2", obs2(), idle_v(0));
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_reset_idle", obs1(), idle_v(0));

`ifdef SAR_SEQ_CONTINUOUS_EN
        // Free-running: two back-to-back conversions, abort lands on the second DONE.
        bus1.start = 1'b1;
        push_conv(8, 4, 0, -1);
        push_conv(8, 4, 0, -1);
        sb.push_back(idle_v(0));
        sb.push_back(idle_v(0));
        run_sb(1, "cont", 0, 43);
        bus1.abort = 1'b0;
`else
        // Single conversion with a one-cycle start.
        bus1.start = 1'b1;
        push_conv(8, 4, 0, -1);
        sb.push_back(idle_v(0));
        run_sb(1, "conv1", 0, -1);

        // start held 40 cycles: exactly two conversions with one idle cycle between.
        bus1.start = 1'b1;
        push_conv(8, 4, 0, -1);
        sb.push_back(idle_v(0));
        push_conv(8, 4, 0, -1);
        for (int k = 0; k < 3; k++) sb.push_back(idle_v(0));
        run_sb(1, "held", 40, -1);

        // Abort in the compare cycle of bit 3; bit_idx holds 3 afterwards.
        bus1.start = 1'b1;
        push_conv(8, 4, 0, 14);
        sb.push_back(idle_v(3));
        sb.push_back(idle_v(3));
        run_sb(1, "abort", 0, 13);
        bus1.abort = 1'b0;

        // Async reset mid-SAMP, between edges.
        bus1.start = 1'b1;
        push_conv(8, 4, 3, 3);
        run_sb(1, "pre_rst", 0, -1);
        #2 rst_n = 1'b0;
        #1 check_val("async_rst", obs1(), idle_v(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) sb.push_back(idle_v(0));
        run_sb(1, "post_rst", -1, -1);

        // Minimum configuration, with start and abort raised together in IDLE.
        bus2.start = 1'b1;
        bus2.abort = 1'b1;
        push_conv(1, 1, 0, -1);
        sb.push_back(idle_v(0));
        run_sb(2, "min", 0, -1);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
